// File: rtl/float_pkg.sv
// FP32 field layout, special encodings and classification helpers shared by the ALU float units.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package float_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;
  localparam int          FP32_BIAS = 127;

  // Square-root datapath widths: a 25-bit root (24 significand bits plus a
  // round bit) consumes a 50-bit radicand two bits at a time. The partial
  // remainder never exceeds 2*root, so 28 bits leave comfortable headroom.
  localparam int ROOT_W = 25;
  localparam int RAD_W  = 2 * ROOT_W;
  localparam int REM_W  = 28;

  function automatic logic is_nan(input fp32_t f);
    return (f.exp == 8'hFF) && (f.mant != 23'd0);
  endfunction

  function automatic logic is_inf(input fp32_t f);
    return (f.exp == 8'hFF) && (f.mant == 23'd0);
  endfunction

  function automatic logic is_zero_or_denorm(input fp32_t f);
    return (f.exp == 8'h00);
  endfunction

endpackage

// File: rtl/sqrt_digit_step.sv
// One restoring square-root iteration: resolves a single root bit.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   i_rem   partial remainder before this step
//   i_root  partial root so far (integer value q)
//   i_rad2  next two radicand bits, MSB first
//   o_rem   partial remainder after this step
//   o_bit   root bit resolved by this step
module sqrt_digit_step
  import float_pkg::*;
(
  input  logic [REM_W-1:0]  i_rem,
  input  logic [ROOT_W-1:0] i_root,
  input  logic [1:0]        i_rad2,
  output logic [REM_W-1:0]  o_rem,
  output logic              o_bit
);

  logic [REM_W+1:0] w_shift;
  logic [REM_W+1:0] w_trial;
  logic [REM_W+1:0] w_diff;

  // r' = 4r + d ; trial = 4q + 1 ; keep r' - trial when it does not go negative.
  assign w_shift = {i_rem, i_rad2};
  assign w_trial = {{(REM_W - ROOT_W){1'b0}}, i_root, 2'b01};
  assign w_diff  = w_shift - w_trial;
  assign o_bit   = (w_shift >= w_trial);
  assign o_rem   = o_bit ? w_diff[REM_W-1:0] : w_shift[REM_W-1:0];

  // The remainder is bounded by 2q+1, so the top two bits are always zero.
  logic w_unused;
  assign w_unused = ^{w_diff[REM_W+1:REM_W], w_shift[REM_W+1:REM_W]};

endmodule

// File: rtl/float_sqrt_iter.sv
// FP32 square root by restoring digit recurrence, BITS_PER_CYCLE root bits per cycle.
// Latency: N+1 cycles from accept for normal operands (N = 25/BITS_PER_CYCLE), 1 cycle for specials.
// Backpressure: single outstanding op; in_ready low in CALC/DONE, result held until out_ready.
//
// Ports:
//   clk, areset                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_tag        operand side handshake, FP32 operand, caller tag
//   out_valid/out_ready/out_q/out_tag    result side handshake, FP32 result, returned tag
//   out_invalid, out_inexact             exception flags for out_q
//
// BITS_PER_CYCLE must divide 25 (1, 5 or 25).
module float_sqrt_iter
  import float_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam int N     = ROOT_W / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RAD_W-1:0]  r_rad;
  logic [REM_W-1:0]  r_rem;
  logic [ROOT_W-1:0] r_root;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_exp;
  logic [TAG_W-1:0]  r_tag;
  logic [31:0]       r_q;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_invalid;
  logic              r_inexact;

  fp32_t w_a;
  logic  w_accept;
  logic  w_last;
  assign w_a      = in_a;
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  // ---------------- special-case classification ----------------
  logic        w_special;
  logic [31:0] w_spec_q;
  logic        w_spec_inv;

  always_comb begin
    w_special  = 1'b1;
    w_spec_q   = FP32_QNAN;
    w_spec_inv = 1'b0;
    if (is_nan(w_a)) begin
      w_spec_q = FP32_QNAN;                   // quiet NaN out, no invalid flag
    end else if (w_a.exp == 8'h00 && w_a.mant == 23'd0) begin
      w_spec_q = in_a;                        // signed zero passes through
    end else if (w_a.sign) begin
      w_spec_inv = 1'b1;                      // any negative nonzero, incl. -inf and denormals
    end else if (is_inf(w_a)) begin
      w_spec_q = FP32_PINF;
    end else if (is_zero_or_denorm(w_a)) begin
      w_spec_q = 32'h0000_0000;               // positive denormal flushed to +0
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------- unpack ----------------
  // Odd exponent (exp even, since the bias is odd) doubles the significand
  // so the halved exponent stays exact. Result exponent = E/2 + 127.
  logic [ROOT_W-1:0] w_sig25;
  logic [7:0]        w_res_exp;
  assign w_sig25   = w_a.exp[0] ? {1'b0, 1'b1, w_a.mant} : {1'b1, w_a.mant, 1'b0};
  assign w_res_exp = {1'b0, w_a.exp[7:1]} + 8'd63 + {7'd0, w_a.exp[0]};

  // ---------------- recurrence chain ----------------
  logic [REM_W-1:0]          w_rem  [BITS_PER_CYCLE+1];
  logic [ROOT_W-1:0]         w_root [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] w_bit;

  assign w_rem[0]  = r_rem;
  assign w_root[0] = r_root;

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
    sqrt_digit_step u_step (
      .i_rem  (w_rem[k]),
      .i_root (w_root[k]),
      .i_rad2 (r_rad[RAD_W-1-2*k -: 2]),
      .o_rem  (w_rem[k+1]),
      .o_bit  (w_bit[k])
    );
    assign w_root[k+1] = {w_root[k][ROOT_W-2:0], w_bit[k]};
  end

  // ---------------- round to nearest even ----------------
  // The root of a value in [1,4) lies in [1,2), so the increment never
  // carries out of the 24-bit significand.
  logic [ROOT_W-1:0] w_fin_root;
  logic              w_sticky;
  logic [23:0]       w_sig;
  assign w_fin_root = w_root[BITS_PER_CYCLE];
  assign w_sticky   = |w_rem[BITS_PER_CYCLE];
  assign w_sig      = w_fin_root[ROOT_W-1:1]
                    + {23'd0, w_fin_root[0] & (w_sticky | w_fin_root[1])};

  logic w_unused;
  assign w_unused = w_sig[23];

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rad     <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_tag     <= '0;
      r_q       <= '0;
      r_out_tag <= '0;
      r_invalid <= 1'b0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tag <= in_tag;
            if (w_special) begin
              r_q       <= w_spec_q;
              r_out_tag <= in_tag;
              r_invalid <= w_spec_inv;
              r_inexact <= 1'b0;
            end else begin
              r_rad  <= {w_sig25, {ROOT_W{1'b0}}};
              r_rem  <= '0;
              r_root <= '0;
              r_cnt  <= '0;
              r_exp  <= w_res_exp;
            end
          end
        end
        S_CALC: begin
          r_rad  <= r_rad << (2 * BITS_PER_CYCLE);
          r_rem  <= w_rem[BITS_PER_CYCLE];
          r_root <= w_fin_root;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_q       <= {1'b0, r_exp, w_sig[22:0]};
            r_out_tag <= r_tag;
            r_invalid <= 1'b0;
            r_inexact <= w_fin_root[0] | w_sticky;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_q       <= '0;
            r_out_tag <= '0;
            r_invalid <= 1'b0;
            r_inexact <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_q       = r_q;
  assign out_tag     = r_out_tag;
  assign out_invalid = r_invalid;
  assign out_inexact = r_inexact;

endmodule
